// File: rtl/relu_maxpool_unit.sv
// ReLU + 2x2 max-pool over one convolution strip held in a synchronous-read BRAM.
// Each output pixel takes six cycles: four reads, one flush for the BRAM latency, one write.
module relu_maxpool_unit #(
  parameter int IN_W = 222,
  parameter int IN_H = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              conv_done,
  output logic [15:0]       rd_addr,
  input  logic signed [8:0] rd_data,
  output logic              wr_en,
  output logic [13:0]       wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;

  localparam logic [15:0] IN_W_L  = 16'(IN_W);
  localparam logic [15:0] OUT_W_L = 16'(OUT_W);
  localparam logic [15:0] OUT_H_L = 16'(OUT_H);

  typedef enum logic [2:0] {
    IDLE, RD0, RD1, RD2, RD3, FLUSH, WRITE, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        orow_q, orow_d;
  logic [15:0]        ocol_q, ocol_d;
  logic [13:0]        wr_addr_q, wr_addr_d;
  logic signed [8:0]  max_q, max_d;
  logic [15:0]        base;

  // Top-left pixel of the current 2x2 window.
  assign base = ({orow_q[14:0], 1'b0} * IN_W_L) + {ocol_q[14:0], 1'b0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      orow_q    <= '0;
      ocol_q    <= '0;
      wr_addr_q <= '0;
      max_q     <= '0;
    end else begin
      state_q   <= state_d;
      orow_q    <= orow_d;
      ocol_q    <= ocol_d;
      wr_addr_q <= wr_addr_d;
      max_q     <= max_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    orow_d    = orow_q;
    ocol_d    = ocol_q;
    wr_addr_d = wr_addr_q;
    max_d     = max_q;
    rd_addr   = '0;
    wr_en     = 1'b0;
    wr_data   = '0;

    case (state_q)
      IDLE: begin
        if (start && conv_done) begin
          state_d   = RD0;
          orow_d    = '0;
          ocol_d    = '0;
          wr_addr_d = '0;
        end
      end
      RD0: begin
        rd_addr = base;
        state_d = RD1;
      end
      // rd_data always belongs to the address issued one state earlier.
      RD1: begin
        rd_addr = base + 16'd1;
        max_d   = rd_data;
        state_d = RD2;
      end
      RD2: begin
        rd_addr = base + IN_W_L;
        if (rd_data > max_q) max_d = rd_data;
        state_d = RD3;
      end
      RD3: begin
        rd_addr = base + IN_W_L + 16'd1;
        if (rd_data > max_q) max_d = rd_data;
        state_d = FLUSH;
      end
      FLUSH: begin
        if (rd_data > max_q) max_d = rd_data;
        state_d = WRITE;
      end
      WRITE: begin
        wr_en   = 1'b1;
        wr_data = max_q[8] ? 8'd0 : max_q[7:0];
        if (ocol_q < OUT_W_L - 16'd1) begin
          ocol_d    = ocol_q + 16'd1;
          wr_addr_d = wr_addr_q + 14'd1;
          state_d   = RD0;
        end else if (orow_q < OUT_H_L - 16'd1) begin
          ocol_d    = '0;
          orow_d    = orow_q + 16'd1;
          wr_addr_d = wr_addr_q + 14'd1;
          state_d   = RD0;
        end else begin
          wr_addr_d = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_addr = wr_addr_q;
  assign busy    = (state_q != IDLE) && (state_q != DONE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_relu_maxpool_unit.sv
// Directed bench for relu_maxpool_unit: BRAM model, expected-write scoreboard and a
// monitor that checks writes, window read addresses, latency and busy/done timing.
module tb_relu_maxpool_unit;

  localparam int IN_W  = 222;
  localparam int IN_H  = 28;
  localparam int NWIN  = 1554;
  localparam int NBUSY = 9324;

  logic              clk;
  logic              reset;
  logic              start;
  logic              conv_done;
  logic [15:0]       rd_addr;
  logic signed [8:0] rd_data;
  logic              wr_en;
  logic [13:0]       wr_addr;
  logic [7:0]        wr_data;
  logic              busy;
  logic              done;

  relu_maxpool_unit #(.IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk(clk), .reset(reset), .start(start), .conv_done(conv_done),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [8:0] mem [0:IN_W*IN_H-1];

  always @(posedge clk) begin
    if (int'(rd_addr) < IN_W*IN_H) rd_data <= mem[rd_addr];
    else                           rd_data <= 9'sd0;
  end

  typedef struct {
    logic [13:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t    expq[$];
  int     checks = 0;
  int     errors = 0;
  int     nwr    = 0;
  int     cyc    = 0;
  int     t0     = 0;
  int     busy_cnt = 0;
  bit     first_pend = 0;
  bit     prev_busy = 0;
  bit     prev_done = 0;
  logic [15:0] hist [1:5];

  // Hand-computed results of the five specially loaded windows; all others read -5.
  logic [7:0] exp_tab [0:4] = '{8'd12, 8'd255, 8'd0, 8'd0, 8'd100};

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_windows(input int n);
    wr_t e;
    for (int k = 0; k < n; k++) begin
      e.a = 14'(k);
      e.d = (k < 5) ? exp_tab[k] : 8'd0;
      expq.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk({name, "_timeout"}, 0, 1);
  endtask

  // Monitor: scoreboard pops, first-write latency, window read addresses, busy/done timing.
  initial begin
    wr_t e;
    for (int i = 1; i <= 5; i++) hist[i] = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0; prev_busy = 0; prev_done = 0; first_pend = 0;
      end else begin
        cyc++;
        if (busy && !prev_busy) begin
          t0 = cyc;
          first_pend = 1;
        end
        if (busy) busy_cnt++;
        if (done && !prev_done) begin
          chk("busy_cycles", busy_cnt, NBUSY);
          chk("done_after_busy", prev_busy, 1);
          busy_cnt = 0;
        end
        if (wr_en) begin
          nwr++;
          if (first_pend) begin
            chk("first_write_latency", cyc - t0, 5);
            first_pend = 0;
          end
          if (wr_addr == 14'd0) begin
            chk("w0_rd0", hist[5], 0);
            chk("w0_rd1", hist[4], 1);
            chk("w0_rd2", hist[3], 222);
            chk("w0_rd3", hist[2], 223);
          end
          if (wr_addr == 14'd1553) begin
            chk("wlast_rd0", hist[5], 5992);
            chk("wlast_rd1", hist[4], 5993);
            chk("wlast_rd2", hist[3], 6214);
            chk("wlast_rd3", hist[2], 6215);
          end
          if (expq.size() == 0) begin
            chk("unexpected_write_addr", wr_addr, -1);
          end else begin
            e = expq.pop_front();
            chk("wr_addr", wr_addr, e.a);
            chk("wr_data", wr_data, e.d);
          end
        end
        for (int i = 5; i > 1; i--) hist[i] = hist[i-1];
        hist[1] = rd_addr;
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  initial begin
    int n0;
    int n;
    bit bad;

    reset = 1'b1; start = 1'b0; conv_done = 1'b0;
    for (int i = 0; i < IN_W*IN_H; i++) mem[i] = -9'sd5;
    mem[0] = 9'sd3;     mem[1] = -9'sd7;    mem[222] = 9'sd12;   mem[223] = 9'sd5;
    mem[2] = -9'sd256;  mem[3] = -9'sd256;  mem[224] = -9'sd256; mem[225] = 9'sd255;
    mem[4] = -9'sd256;  mem[5] = -9'sd1;    mem[226] = -9'sd2;   mem[227] = -9'sd3;
    mem[6] = -9'sd4;    mem[7] = -9'sd4;    mem[228] = -9'sd4;   mem[229] = -9'sd4;
    mem[8] = 9'sd7;     mem[9] = 9'sd100;   mem[230] = 9'sd100;  mem[231] = -9'sd1;

    repeat (3) @(negedge clk);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_wr_en",   wr_en,   0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_done",    done,    0);
    reset = 1'b0;

    // start without conv_done must not launch anything.
    start = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || wr_en || rd_addr != 16'd0) bad = 1;
    end
    chk("gated_activity", bad, 0);

    // Pass A: full strip, with start/conv_done wiggled while busy.
    n0 = nwr;
    push_windows(NWIN);
    conv_done = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0; conv_done = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0; conv_done = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b1;
    wait_done("passA");
    chk("passA_writes", nwr - n0, NWIN);
    chk("passA_wr_addr_wrap", wr_addr, 0);

    bad = 0;
    n0 = nwr;
    repeat (200) begin
      @(negedge clk);
      if (!done || busy) bad = 1;
    end
    chk("done_hold", bad, 0);
    chk("no_second_pass", nwr - n0, 0);
    chk("passA_queue_empty", expq.size(), 0);
    start = 1'b0;
    @(negedge clk);
    chk("back_idle_done", done, 0);
    chk("back_idle_busy", busy, 0);

    // Pass B: reset in window 500 RD2 (base 1888, RD2 address 2110).
    n0 = nwr;
    push_windows(500);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!((nwr - n0) == 500 && rd_addr == 16'd2110) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_w500_rd2", rd_addr, 2110);
    reset = 1'b1;
    #1;
    chk("midrst_wr_en",   wr_en,   0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_busy",    busy,    0);
    chk("midrst_writes",  nwr - n0, 500);
    chk("midrst_queue_empty", expq.size(), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("w500_never_written", nwr - n0, 500);

    // Pass C: restart from window 0 after the reset.
    n0 = nwr;
    push_windows(NWIN);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("passC");
    chk("passC_writes", nwr - n0, NWIN);
    chk("passC_queue_empty", expq.size(), 0);
    repeat (3) @(negedge clk);
    chk("passC_idle", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/relu_maxpool_unit.md
RELU_MAXPOOL_UNIT -- requirements
Module: relu_maxpool_unit

Interface
REQ-001 SHALL have parameter IN_W, default 222, meaning conv output strip width (columns).
REQ-002 SHALL have parameter IN_H, default 28, meaning conv output strip height (rows).
REQ-003 SHALL derive localparams OUT_W = IN_W/2 (111) and OUT_H = IN_H/2 (14), both floor division.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request to pool one strip.
REQ-007 SHALL have port conv_done, input, 1 bit: upstream convolution strip memory is complete and valid.
REQ-008 SHALL have port rd_addr, output, 16 bits: read address to the conv result memory.
REQ-009 SHALL have port rd_data, input, 9 bits signed: conv result, valid one cycle after rd_addr is presented (synchronous BRAM).
REQ-010 SHALL have port wr_en, output, 1 bit: pooled-map write strobe.
REQ-011 SHALL have port wr_addr, output, 14 bits: pooled-map address = orow*OUT_W + ocol.
REQ-012 SHALL have port wr_data, output, 8 bits unsigned: ReLU'd 2x2 maximum.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-014 SHALL have port done, output, 1 bit: high while in DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RD0, RD1, RD2, RD3, FLUSH, WRITE, DONE.
REQ-016 IDLE -> RD0 when start=1 and conv_done=1, clearing orow, ocol and wr_addr to 0; otherwise stay in IDLE.
REQ-017 Window base SHALL be base = (2*orow)*IN_W + 2*ocol.
REQ-018 rd_addr SHALL be base in RD0, base+1 in RD1, base+IN_W in RD2, base+IN_W+1 in RD3; don't-care elsewhere.
REQ-019 The running max SHALL load rd_data in RD1, and SHALL update in RD2, RD3 and FLUSH to the signed maximum of itself and rd_data.
REQ-020 Comparison SHALL be signed 9-bit; on equal values the result is unchanged.
REQ-021 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_data = 0 if max < 0, else max[7:0] (a 9-bit signed maximum of at most 255 needs no saturation).
REQ-022 After WRITE: if ocol < OUT_W-1, increment ocol and go to RD0.
REQ-023 After WRITE: else if orow < OUT_H-1, set ocol=0, increment orow and go to RD0.
REQ-024 After WRITE: else go to DONE.
REQ-025 wr_addr SHALL increment by 1 after each WRITE, wrapping to 0 on entry to DONE.
REQ-026 Each window SHALL take exactly 6 cycles, giving OUT_W*OUT_H = 1554 writes and 9324 busy cycles with defaults.
REQ-027 DONE -> IDLE when start=0; DONE SHALL hold while start=1, so one start level yields one pass.
REQ-028 start or conv_done changes while busy SHALL be ignored.
REQ-029 With odd IN_W or IN_H, the last column or row SHALL never be read.
REQ-030 wr_en SHALL be 0 in every state except WRITE.

Reset
REQ-031 On reset=1, asynchronously: state=IDLE; rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0; orow, ocol and max cleared.
REQ-032 Reset mid-window SHALL suppress any pending write; the next accepted start SHALL restart from window 0.

Verification
REQ-033 Reset and window 0: assert reset -> all outputs 0. Load memory addr0=3, addr1=-7, addr222=12, addr223=5, start -> first wr_en in cycle 6 after leaving IDLE with wr_addr=0, wr_data=12.
REQ-034 Extremes: window {-256,-256,-256,255} -> 255; window {-256,-1,-2,-3} -> 0; window {-4,-4,-4,-4} -> 0.
REQ-035 Full strip, memory = -5 everywhere -> exactly 1554 writes, all data 0; last write wr_addr=1553 with rd_addr sequence 5992, 5993, 6214, 6215; done rises the cycle after the 9324th busy cycle.
REQ-036 Gating: start=1 with conv_done=0 for 100 cycles -> busy=0, no rd_addr or wr_en activity. Start pulsed again during busy -> still 1554 writes. start held high after DONE -> stays in DONE, no second pass.
REQ-037 Reset mid-operation: assert reset during window 500 RD2 -> wr_en=0 and wr_addr=0 immediately, window 500 is never written; restart -> first write wr_addr=0 with correct data.
